// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler that streams fixed-size ROM message slots into a shared UART TX FIFO.
// Requests are latched, one slot is granted at a time, and the ROM's one-cycle read latency is covered by FETCH.
module uart_msg_scheduler #(
  parameter int          N_REQ   = 4,
  parameter int          MSG_LEN = 16,
  parameter logic [7:0]  TERM    = 8'h00
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [N_REQ-1:0]                          req,
  input  logic                                      tx_full,
  input  logic [7:0]                                rom_data,
  output logic [$clog2(N_REQ)+$clog2(MSG_LEN)-1:0]  rom_addr,
  output logic                                      wr,
  output logic [7:0]                                w_data,
  output logic                                      busy,
  output logic                                      done_tick,
  output logic [$clog2(N_REQ)-1:0]                  done_id
);

  localparam int GW = $clog2(N_REQ);
  localparam int OW = $clog2(MSG_LEN);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [OW-1:0]    offset_q, offset_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_grant_q, last_grant_d;
  logic             busy_q, busy_d;
  logic             done_tick_q, done_tick_d;
  logic [GW-1:0]    done_id_q, done_id_d;

  logic             arb_found;
  logic [GW-1:0]    arb_pick;
  int               arb_idx;

  // Round-robin search starting just after the most recently finished slot.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      arb_idx = (int'(last_grant_q) + k) % N_REQ;
      if (!arb_found && pending_q[arb_idx[GW-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | req;
    offset_d     = offset_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d  = arb_pick;
          offset_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        if (rom_data == TERM) begin
          state_d = DONE;
        end else if (!tx_full) begin
          if (offset_q == OW'(MSG_LEN - 1)) begin
            state_d = DONE;
          end else begin
            offset_d = offset_q + 1'b1;
            state_d  = FETCH;
          end
        end
      end
      DONE: begin
        // A request arriving in this same cycle re-arms the slot.
        pending_d    = (pending_q & ~(ONE_HOT0 << grant_q)) | req;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    done_tick_d = (state_d == DONE);
    done_id_d   = (state_d == DONE) ? grant_q : done_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      offset_q     <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      busy_q       <= 1'b0;
      done_tick_q  <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      offset_q     <= offset_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      done_tick_q  <= done_tick_d;
      done_id_q    <= done_id_d;
    end
  end

  assign rom_addr  = {grant_q, offset_q};
  assign wr        = (state_q == SEND) && (rom_data != TERM) && !tx_full;
  assign w_data    = rom_data;
  assign busy      = busy_q;
  assign done_tick = done_tick_q;
  assign done_id   = done_id_q;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Scoreboard bench for uart_msg_scheduler: stimulus pushes expected bytes/done ids, a negedge monitor pops and compares.
module tb_uart_msg_scheduler;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       tx_full;
  logic [7:0] rom_data;
  logic [5:0] rom_addr;
  logic       wr;
  logic [7:0] w_data;
  logic       busy;
  logic       done_tick;
  logic [1:0] done_id;

  uart_msg_scheduler #(.N_REQ(4), .MSG_LEN(16), .TERM(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .tx_full(tx_full),
    .rom_data(rom_data), .rom_addr(rom_addr), .wr(wr), .w_data(w_data),
    .busy(busy), .done_tick(done_tick), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [0:63];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int         total = 0;
  int         bad = 0;
  int         wr_cnt = 0;
  logic [7:0] exp_q[$];
  int         done_q[$];
  logic [7:0] mon_e;
  int         mon_d;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (wr === 1'b1) begin
        wr_cnt++;
        chk("wr_while_full", int'(tx_full), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0h expected no write", w_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("w_data", int'(w_data), int'(mon_e));
        end
      end
      if (done_tick === 1'b1) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got id %0d expected no done", done_id);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_id", int'(done_id), mon_d);
        end
      end
    end
  end

  task automatic push_str(input logic [127:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s[8*(n-1-i) +: 8]);
  endtask

  task automatic push_ramp();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk) req = m;
    @(negedge clk) req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_quiet(input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0 && busy == 1'b0) break;
    end
    if (i == 2000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d bytes %0d dones left expected 0", name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (4) @(negedge clk);
    chk({name, "_busy"}, int'(busy), 0);
  endtask

  // Returns at a negedge in FETCH (wr low) once n writes have been seen.
  task automatic wait_wr(input string name, input int n);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wr_cnt >= n && wr == 1'b0) break;
    end
    if (i == 500) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", name, wr_cnt, n);
    end
  endtask

  task automatic wait_sig(input string name, input bit want_done);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (want_done ? (done_tick == 1'b1) : (wr == 1'b1)) break;
    end
    if (i == 500) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no event expected one", name);
    end
  endtask

  int         base;
  logic [5:0] held_addr;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'h48; rom[1] = 8'h65; rom[2] = 8'h6C; rom[3] = 8'h6C; rom[4] = 8'h6F;
    for (int i = 0; i < 16; i++) rom[16+i] = 8'(i + 1);
    rom[32] = 8'h41; rom[33] = 8'h42; rom[34] = 8'h43;
    rom[48] = 8'h31; rom[49] = 8'h32; rom[50] = 8'h33;
    rom[51] = 8'h34; rom[52] = 8'h35; rom[53] = 8'h36;

    reset_n = 1'b0; req = '0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", int'(wr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_tick", int'(done_tick), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_done_id", int'(done_id), 0);
    reset_n = 1'b1;

    // T1: single "Hello"
    push_str("Hello", 5);
    done_q.push_back(0);
    pulse(4'b0001);
    wait_quiet("t1");

    // T2: arbitration from reset, then search resumes after slot 2
    do_reset();
    push_str("Hello", 5);
    push_str("ABC", 3);
    done_q.push_back(0);
    done_q.push_back(2);
    pulse(4'b0101);
    wait_quiet("t2a");
    // T4 folded in: slot1 is a full 16-byte slot
    push_str("Hello", 5);
    push_ramp();
    done_q.push_back(0);
    done_q.push_back(1);
    pulse(4'b0011);
    wait_quiet("t2b");

    // T3: backpressure mid-message
    base = wr_cnt;
    push_ramp();
    done_q.push_back(1);
    pulse(4'b0010);
    wait_wr("t3_start", base + 3);
    tx_full = 1'b1;
    held_addr = rom_addr;
    chk("t3_addr", int'(rom_addr), 19);
    repeat (20) begin
      @(negedge clk);
      chk("t3_stall_wr", int'(wr), 0);
      chk("t3_stall_addr", int'(rom_addr), int'(held_addr));
    end
    @(posedge clk);
    #1 tx_full = 1'b0;
    wait_quiet("t3");

    // T5: reset after third byte of slot3
    base = wr_cnt;
    push_str("123", 3);
    pulse(4'b1000);
    wait_wr("t5_start", base + 3);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_wr", int'(wr), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done_tick", int'(done_tick), 0);
    chk("t5_rst_rom_addr", int'(rom_addr), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_writes", wr_cnt - base, 3);
    chk("t5_leftover", exp_q.size(), 0);

    // T6: re-request during SEND and during DONE -> served twice
    push_str("Hello", 5);
    push_str("Hello", 5);
    done_q.push_back(0);
    done_q.push_back(0);
    pulse(4'b0001);
    wait_sig("t6_send", 1'b0);
    req = 4'b0001;
    @(negedge clk) req = '0;
    wait_sig("t6_done", 1'b1);
    req = 4'b0001;
    @(negedge clk) req = '0;
    wait_quiet("t6");

    // T6: empty slot gives done with no writes
    rom[32] = 8'h00;
    base = wr_cnt;
    done_q.push_back(2);
    pulse(4'b0100);
    wait_quiet("t6_empty");
    chk("t6_empty_writes", wr_cnt - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
